alu_req_arbiter: RTL and testbench
==================================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters sharing one ALU (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the operand and result width.
REQ-003 SHALL have parameter OP_WIDTH, default 4, the ALU opcode width.
REQ-004 SHALL have parameter TIMEOUT, default 16, the maximum WAIT cycles before abort (>=2).
REQ-005 SHALL have port CLK  in  1  clock, all flops on the rising edge.
REQ-006 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port REQ_VLD  in  N_REQ  per-requester operation request.
REQ-008 SHALL have port REQ_OP  in  N_REQ*OP_WIDTH  per-requester opcode; slice i belongs to requester i.
REQ-009 SHALL have port REQ_MOVI  in  N_REQ*2  per-requester operand-B source select.
REQ-010 SHALL have port REQ_A  in  N_REQ*DATA_WIDTH  per-requester operand A.
REQ-011 SHALL have port REQ_B  in  N_REQ*DATA_WIDTH  per-requester operand B.
REQ-012 SHALL have port REQ_GNT  out  N_REQ  one-hot one-cycle acceptance pulse.
REQ-013 SHALL have ports ALU_ACT out 1, ALU_OP out OP_WIDTH, ALU_MOVI out 2, ALU_A out DATA_WIDTH, ALU_B out DATA_WIDTH, carrying the issue to the ALU.
REQ-014 SHALL have ports ALU_RDY in 1, ALU_RES in DATA_WIDTH, ALU_RES_VLD in 1, carrying the ALU status and result.
REQ-015 SHALL have ports RSP_VLD out N_REQ (one-hot), RSP_DATA out DATA_WIDTH, ERR out 1 (sticky error).

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-017 In IDLE, when any REQ_VLD bit is set and ALU_RDY=1, SHALL select winner w round-robin, searching upward from PTR with wrap at N_REQ-1->0.
REQ-018 On that same edge SHALL register w's OP/MOVI/A/B into the ALU_* outputs and move to ISSUE.
REQ-019 If ALU_RDY=0 in IDLE, SHALL stay in IDLE and grant nothing.
REQ-020 In ISSUE (exactly one cycle), ALU_ACT=1 and REQ_GNT[w]=1 simultaneously; next state is WAIT.
REQ-021 Grant latency SHALL be 1 cycle: REQ_VLD sampled at edge t gives GNT/ACT high during cycle t+1.
REQ-022 Requester SHALL hold REQ_VLD and operands until granted; withdrawal before grant is legal, and a withdrawn request is not granted.
REQ-023 ALU_OP/ALU_MOVI/ALU_A/ALU_B SHALL hold their values until the next issue; ALU_ACT=0 outside ISSUE.
REQ-024 In WAIT, on ALU_RES_VLD=1: RSP_DATA<=ALU_RES, RSP_VLD[w]=1 for exactly the next cycle, PTR<=(w+1) mod N_REQ, next state IDLE.
REQ-025 A new selection SHALL occur in the cycle RSP_VLD is high (IDLE), giving back-to-back throughput of 1 op per 3+ALU-latency cycles.
REQ-026 A WAIT cycle counter SHALL clear on entry; if TIMEOUT cycles pass without ALU_RES_VLD: ERR<=1, RSP_VLD[w]=1 with RSP_DATA=0, PTR advances, return to IDLE.
REQ-027 ALU_RES_VLD outside WAIT SHALL be ignored for data and SHALL set ERR.
REQ-028 RSP_DATA SHALL hold its last value between responses.
REQ-029 REQ_GNT and RSP_VLD SHALL each be one-hot or zero at all times.
REQ-030 ERR SHALL clear only on reset.

Reset
REQ-031 RST_N=0 SHALL immediately force state IDLE, PTR=0, counter=0, and REQ_GNT, RSP_VLD, ALU_ACT, ALU_OP, ALU_MOVI, ALU_A, ALU_B, RSP_DATA, ERR all to 0.
REQ-032 Reset mid-operation SHALL abandon the in-flight op with no response; a result arriving after release is treated as stray (REQ-027).
REQ-033 The first selection after reset release SHALL occur on the first rising edge with RST_N=1.

Verification
REQ-034 Single req: REQ_VLD=0001, op ADD, A=0x05, B=0x03, ALU returns 0x08 after 2 cycles -> GNT=0001 and ACT in cycle 1, RSP_VLD=0001 with RSP_DATA=0x08, ERR=0.
REQ-035 Fairness: REQ_VLD=1111 held for 8 ops -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Busy ALU: REQ_VLD=0100 with ALU_RDY=0 for 5 cycles -> no GNT/ACT; GNT=0100 one cycle after ALU_RDY rises.
REQ-037 Timeout: TIMEOUT=16, ALU_RES_VLD never asserted -> after 16 WAIT cycles RSP_VLD[w]=1, RSP_DATA=0x00, ERR=1 sticky; the next request is still served.
REQ-038 Stray/reset: ALU_RES_VLD pulsed in IDLE -> ERR=1 with no RSP_VLD; RST_N low during WAIT -> all outputs 0 at once, PTR=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one multi-cycle ALU among N_REQ requesters. An IDLE/ISSUE/WAIT FSM
//   picks one requester round-robin, presents its operation to the ALU for
//   exactly one cycle, then waits for the result. The result goes back as a
//   one-cycle response pulse. If the ALU does not answer, the FSM times out
//   and returns zero data with a sticky error flag.
//
// Ports
//   CLK, RST_N           clock (rising edge) / async active-low reset
//   REQ_VLD[N]           per-requester request
//   REQ_OP/MOVI/A/B      per-requester operation fields, slice i = requester i
//   REQ_GNT[N]           one-hot acceptance pulse (ISSUE cycle)
//   ALU_ACT/OP/MOVI/A/B  issue to the ALU; the fields hold until the next issue
//   ALU_RDY              ALU can accept a new op
//   ALU_RES/ALU_RES_VLD  ALU result
//   RSP_VLD[N]/RSP_DATA  one-hot response pulse and held response data
//   ERR                  sticky: timeout or stray result; cleared by reset only
// ---------------------------------------------------------------------------

// Per-lane slice: packs one requester's fields and decodes its own
// grant/response strobe from the shared winner index.
module alu_req_arbiter_lane #(
  parameter int LANE       = 0,
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int PTR_W      = 2
) (
  input  logic [OP_WIDTH-1:0]              op_i,
  input  logic [1:0]                       movi_i,
  input  logic [DATA_WIDTH-1:0]            a_i,
  input  logic [DATA_WIDTH-1:0]            b_i,
  input  logic                             issue_i,
  input  logic                             rsp_i,
  input  logic [PTR_W-1:0]                 win_i,
  output logic [OP_WIDTH+2+2*DATA_WIDTH-1:0] req_o,
  output logic                             gnt_o,
  output logic                             rsp_vld_o
);
  logic hit;

  assign hit       = (win_i == PTR_W'(LANE));
  assign req_o     = {op_i, movi_i, a_i, b_i};
  // Only one lane can match win_i, so GNT/RSP_VLD are one-hot by construction.
  assign gnt_o     = issue_i & hit;
  assign rsp_vld_o = rsp_i & hit;
endmodule

module alu_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N_REQ-1:0]            REQ_VLD,
  input  logic [N_REQ*OP_WIDTH-1:0]   REQ_OP,
  input  logic [N_REQ*2-1:0]          REQ_MOVI,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_A,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_B,
  output logic [N_REQ-1:0]            REQ_GNT,
  output logic                        ALU_ACT,
  output logic [OP_WIDTH-1:0]         ALU_OP,
  output logic [1:0]                  ALU_MOVI,
  output logic [DATA_WIDTH-1:0]       ALU_A,
  output logic [DATA_WIDTH-1:0]       ALU_B,
  input  logic                        ALU_RDY,
  input  logic [DATA_WIDTH-1:0]       ALU_RES,
  input  logic                        ALU_RES_VLD,
  output logic [N_REQ-1:0]            RSP_VLD,
  output logic [DATA_WIDTH-1:0]       RSP_DATA,
  output logic                        ERR
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int REQ_W = OP_WIDTH + 2 + 2*DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [1:0]            movi;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [1:0]            movi_q, movi_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_q, rsp_d;
  logic                  err_q, err_d;

  logic [N_REQ-1:0][REQ_W-1:0] lane_req;
  req_t [N_REQ-1:0]            req;
  logic                        issue;
  logic                        sel_found;
  logic [PTR_W-1:0]            sel_idx;
  logic [PTR_W-1:0]            cand;
  logic [PTR_W-1:0]            next_ptr;

  assign issue = (state_q == S_ISSUE);

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    alu_req_arbiter_lane #(
      .LANE       (i),
      .DATA_WIDTH (DATA_WIDTH),
      .OP_WIDTH   (OP_WIDTH),
      .PTR_W      (PTR_W)
    ) u_lane (
      .op_i      (REQ_OP[i*OP_WIDTH +: OP_WIDTH]),
      .movi_i    (REQ_MOVI[i*2 +: 2]),
      .a_i       (REQ_A[i*DATA_WIDTH +: DATA_WIDTH]),
      .b_i       (REQ_B[i*DATA_WIDTH +: DATA_WIDTH]),
      .issue_i   (issue),
      .rsp_i     (rsp_q),
      .win_i     (win_q),
      .req_o     (lane_req[i]),
      .gnt_o     (REQ_GNT[i]),
      .rsp_vld_o (RSP_VLD[i])
    );
    assign req[i] = lane_req[i];
  end

  // Round-robin pick: walk from the farthest candidate back toward PTR so the
  // last hit written is the first requester at or above PTR (with wrap).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (REQ_VLD[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign next_ptr = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    movi_d     = movi_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_d      = 1'b0;
    err_d      = err_q;

    // A result with nothing outstanding is a protocol error; its data is dropped.
    if (ALU_RES_VLD && (state_q != S_WAIT)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found && ALU_RDY) begin
          win_d   = sel_idx;
          op_d    = req[sel_idx].op;
          movi_d  = req[sel_idx].movi;
          a_d     = req[sel_idx].a;
          b_d     = req[sel_idx].b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ALU_RES_VLD) begin
          rsp_data_d = ALU_RES;
          rsp_d      = 1'b1;
          ptr_d      = next_ptr;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT-th silent WAIT cycle: answer the requester with zero.
          rsp_data_d = '0;
          rsp_d      = 1'b1;
          err_d      = 1'b1;
          ptr_d      = next_ptr;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      movi_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      movi_q     <= movi_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_q      <= rsp_d;
      err_q      <= err_d;
    end
  end

  assign ALU_ACT  = issue;
  assign ALU_OP   = op_q;
  assign ALU_MOVI = movi_q;
  assign ALU_A    = a_q;
  assign ALU_B    = b_q;
  assign RSP_DATA = rsp_data_q;
  assign ERR      = err_q;

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(REQ_GNT));
  a_rsp_onehot: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(RSP_VLD));
endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int TO = 16;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [N-1:0]    REQ_VLD = '0;
  logic [N*OW-1:0] REQ_OP = '0;
  logic [N*2-1:0]  REQ_MOVI = '0;
  logic [N*DW-1:0] REQ_A = '0;
  logic [N*DW-1:0] REQ_B = '0;
  logic [N-1:0]    REQ_GNT;
  logic            ALU_ACT;
  logic [OW-1:0]   ALU_OP;
  logic [1:0]      ALU_MOVI;
  logic [DW-1:0]   ALU_A;
  logic [DW-1:0]   ALU_B;
  logic            ALU_RDY = 1'b0;
  logic [DW-1:0]   ALU_RES = '0;
  logic            ALU_RES_VLD = 1'b0;
  logic [N-1:0]    RSP_VLD;
  logic [DW-1:0]   RSP_DATA;
  logic            ERR;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_req_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VLD(REQ_VLD), .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_GNT(REQ_GNT), .ALU_ACT(ALU_ACT), .ALU_OP(ALU_OP), .ALU_MOVI(ALU_MOVI),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_RDY(ALU_RDY), .ALU_RES(ALU_RES),
    .ALU_RES_VLD(ALU_RES_VLD), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .ERR(ERR)
  );

  // Requester i: op=i+1, movi=3-i, A=0x10*i+1, B=0x20+i
  task automatic load_operands();
    for (int i = 0; i < N; i++) begin
      REQ_OP[i*OW +: OW]   = OW'(i + 1);
      REQ_MOVI[i*2 +: 2]   = 2'(3 - i);
      REQ_A[i*DW +: DW]    = DW'(8'h10 * i + 1);
      REQ_B[i*DW +: DW]    = DW'(8'h20 + i);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", REQ_GNT); end
    checks++; if (RSP_VLD !== 4'b0000) begin failures++; $display("FAIL reset_rsp_vld: got %b expected 0000", RSP_VLD); end
    checks++; if (ALU_ACT !== 1'b0) begin failures++; $display("FAIL reset_act: got %b expected 0", ALU_ACT); end
    checks++; if ({ALU_OP, ALU_MOVI, ALU_A, ALU_B} !== '0) begin failures++; $display("FAIL reset_alu_fields: got %h/%h/%h/%h expected 0", ALU_OP, ALU_MOVI, ALU_A, ALU_B); end
    checks++; if (RSP_DATA !== 8'h00 || ERR !== 1'b0) begin failures++; $display("FAIL reset_data_err: got %h/%b expected 00/0", RSP_DATA, ERR); end
    RST_N = 1'b1;
  endtask

  task automatic test_single();
    load_operands();
    REQ_OP[OW-1:0] = 4'h1; REQ_A[DW-1:0] = 8'h05; REQ_B[DW-1:0] = 8'h03;
    ALU_RDY = 1'b1;
    @(negedge CLK); REQ_VLD = 4'b0001;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0001 || ALU_ACT !== 1'b1) begin failures++; $display("FAIL single_gnt: got gnt=%b act=%b expected 0001/1", REQ_GNT, ALU_ACT); end
    checks++; if (ALU_OP !== 4'h1 || ALU_MOVI !== 2'd3 || ALU_A !== 8'h05 || ALU_B !== 8'h03) begin failures++; $display("FAIL single_fields: got %h/%h/%h/%h expected 1/3/05/03", ALU_OP, ALU_MOVI, ALU_A, ALU_B); end
    REQ_VLD = 4'b0000;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0000 || ALU_ACT !== 1'b0) begin failures++; $display("FAIL single_act_one_cycle: got gnt=%b act=%b expected 0000/0", REQ_GNT, ALU_ACT); end
    @(negedge CLK); ALU_RES = 8'h08; ALU_RES_VLD = 1'b1;
    @(negedge CLK); ALU_RES_VLD = 1'b0;
    checks++; if (RSP_VLD !== 4'b0001 || RSP_DATA !== 8'h08) begin failures++; $display("FAIL single_rsp: got %b/%h expected 0001/08", RSP_VLD, RSP_DATA); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", ERR); end
    @(negedge CLK);
    checks++; if (RSP_VLD !== 4'b0000 || RSP_DATA !== 8'h08 || ALU_A !== 8'h05) begin failures++; $display("FAIL single_hold: got %b/%h/%h expected 0000/08/05", RSP_VLD, RSP_DATA, ALU_A); end
  endtask

  task automatic test_fairness();
    int n;
    do_reset();
    load_operands();
    REQ_VLD = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      n = 0;
      @(negedge CLK);
      while (REQ_GNT === 4'b0000 && n < 6) begin n++; @(negedge CLK); end
      checks++; if (REQ_GNT !== 4'(1 << (j % 4))) begin failures++; $display("FAIL fair_gnt[%0d]: got %b expected %b", j, REQ_GNT, 4'(1 << (j % 4))); end
      checks++; if (ALU_A !== 8'(8'h10 * (j % 4) + 1)) begin failures++; $display("FAIL fair_opA[%0d]: got %h expected %h", j, ALU_A, 8'(8'h10 * (j % 4) + 1)); end
      @(negedge CLK); ALU_RES = 8'(8'h40 + j); ALU_RES_VLD = 1'b1;
      @(negedge CLK); ALU_RES_VLD = 1'b0;
      if (j == 7) REQ_VLD = 4'b0000;
      checks++; if (RSP_VLD !== 4'(1 << (j % 4)) || RSP_DATA !== 8'(8'h40 + j)) begin failures++; $display("FAIL fair_rsp[%0d]: got %b/%h expected %b/%h", j, RSP_VLD, RSP_DATA, 4'(1 << (j % 4)), 8'(8'h40 + j)); end
    end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL fair_err: got %b expected 0", ERR); end
  endtask

  task automatic test_busy();
    int bad;
    ALU_RDY = 1'b0;
    @(negedge CLK); REQ_VLD = 4'b0100;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (REQ_GNT !== 4'b0000 || ALU_ACT !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_no_grant: got %0d grant cycles expected 0", bad); end
    ALU_RDY = 1'b1;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0100 || ALU_ACT !== 1'b1 || ALU_MOVI !== 2'd1) begin failures++; $display("FAIL busy_gnt: got %b/%b/%h expected 0100/1/1", REQ_GNT, ALU_ACT, ALU_MOVI); end
    REQ_VLD = 4'b0000;
    @(negedge CLK); ALU_RES = 8'h5A; ALU_RES_VLD = 1'b1;
    @(negedge CLK); ALU_RES_VLD = 1'b0;
    checks++; if (RSP_VLD !== 4'b0100 || RSP_DATA !== 8'h5A) begin failures++; $display("FAIL busy_rsp: got %b/%h expected 0100/5a", RSP_VLD, RSP_DATA); end
  endtask

  task automatic test_timeout();
    int early;
    @(negedge CLK); REQ_VLD = 4'b0001;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0001 || ERR !== 1'b0) begin failures++; $display("FAIL to_gnt: got %b/%b expected 0001/0", REQ_GNT, ERR); end
    REQ_VLD = 4'b0000;
    early = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge CLK);
      if (RSP_VLD !== 4'b0000) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL to_early: got %0d early responses expected 0", early); end
    @(negedge CLK);
    checks++; if (RSP_VLD !== 4'b0001 || RSP_DATA !== 8'h00) begin failures++; $display("FAIL to_rsp: got %b/%h expected 0001/00", RSP_VLD, RSP_DATA); end
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL to_err: got %b expected 1", ERR); end
    REQ_VLD = 4'b0010;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0010) begin failures++; $display("FAIL to_next_gnt: got %b expected 0010", REQ_GNT); end
    REQ_VLD = 4'b0000;
    @(negedge CLK); ALU_RES = 8'h33; ALU_RES_VLD = 1'b1;
    @(negedge CLK); ALU_RES_VLD = 1'b0;
    checks++; if (RSP_VLD !== 4'b0010 || RSP_DATA !== 8'h33 || ERR !== 1'b1) begin failures++; $display("FAIL to_next_rsp: got %b/%h/%b expected 0010/33/1", RSP_VLD, RSP_DATA, ERR); end
  endtask

  task automatic test_stray_reset();
    do_reset();
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL sr_err_clear: got %b expected 0", ERR); end
    ALU_RES = 8'h77; ALU_RES_VLD = 1'b1;
    @(negedge CLK); ALU_RES_VLD = 1'b0;
    checks++; if (ERR !== 1'b1 || RSP_VLD !== 4'b0000 || RSP_DATA !== 8'h00) begin failures++; $display("FAIL sr_stray: got %b/%b/%h expected 1/0000/00", ERR, RSP_VLD, RSP_DATA); end
    REQ_VLD = 4'b0010;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0010) begin failures++; $display("FAIL sr_gnt1: got %b expected 0010", REQ_GNT); end
    REQ_VLD = 4'b0000;
    @(negedge CLK); ALU_RES = 8'h44; ALU_RES_VLD = 1'b1;
    @(negedge CLK); ALU_RES_VLD = 1'b0;
    checks++; if (RSP_VLD !== 4'b0010 || RSP_DATA !== 8'h44) begin failures++; $display("FAIL sr_rsp1: got %b/%h expected 0010/44", RSP_VLD, RSP_DATA); end
    REQ_VLD = 4'b0100;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0100) begin failures++; $display("FAIL sr_gnt2: got %b expected 0100", REQ_GNT); end
    REQ_VLD = 4'b0000;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++; if (REQ_GNT !== 4'b0000 || RSP_VLD !== 4'b0000 || ALU_ACT !== 1'b0) begin failures++; $display("FAIL sr_rst_strobes: got %b/%b/%b expected 0000/0000/0", REQ_GNT, RSP_VLD, ALU_ACT); end
    checks++; if ({ALU_OP, ALU_MOVI, ALU_A, ALU_B} !== '0) begin failures++; $display("FAIL sr_rst_fields: got %h/%h/%h/%h expected 0", ALU_OP, ALU_MOVI, ALU_A, ALU_B); end
    checks++; if (RSP_DATA !== 8'h00 || ERR !== 1'b0) begin failures++; $display("FAIL sr_rst_data_err: got %h/%b expected 00/0", RSP_DATA, ERR); end
    @(negedge CLK);
    RST_N = 1'b1; REQ_VLD = 4'b1111; ALU_RES = 8'h66; ALU_RES_VLD = 1'b1;
    @(negedge CLK);
    checks++; if (REQ_GNT !== 4'b0001 || ALU_ACT !== 1'b1) begin failures++; $display("FAIL sr_ptr0_gnt: got %b/%b expected 0001/1", REQ_GNT, ALU_ACT); end
    checks++; if (ERR !== 1'b1 || RSP_VLD !== 4'b0000 || RSP_DATA !== 8'h00) begin failures++; $display("FAIL sr_post_stray: got %b/%b/%h expected 1/0000/00", ERR, RSP_VLD, RSP_DATA); end
    REQ_VLD = 4'b0000; ALU_RES_VLD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_busy();
    test_timeout();
    test_stray_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
